// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
//   Definitions shared by the multi-channel clock divider:
//     - default divisor width and reset divisor
//     - channel action encoding used by the per-channel next-state logic
//     - idx_w(): channel-index width, never less than one bit
// ---------------------------------------------------------------------------
package clkdiv_pkg;

  localparam int DIV_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 2;

  // What a channel does on the coming edge, highest priority first.
  typedef enum logic [1:0] {
    ACT_HALT  = 2'd0,  // disabled or divisor 0: park at count 0, outputs low
    ACT_BOUND = 2'd1,  // period boundary (start, sync or wrap): tick, clk high, adopt
    ACT_INC   = 2'd2   // ordinary step inside a period
  } ch_act_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// ---------------------------------------------------------------------------
// clk_div_channel
//   One programmable divider channel. Produces a one-cycle tick per period
//   and a registered square wave that is high for ceil(N/2) cycles and low
//   for the rest. Divisor writes go to a shadow register and are adopted
//   only on a period boundary (or at once while halted), so clk_o never
//   shows a runt pulse.
//
// Ports
//   clk_i     in   1      clock, posedge
//   rst_ni    in   1      asynchronous active-low reset
//   en_i      in   1      run enable
//   sync_i    in   1      restart the period from count 0
//   wr_i      in   1      write wr_val_i into the shadow divisor
//   wr_val_i  in   DIV_W  new divisor
//   tick_o    out  1      one-cycle strobe per period
//   clk_o     out  1      divided square wave
//   pend_o    out  1      shadow divisor written but not yet adopted
// ---------------------------------------------------------------------------
module clk_div_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_val_i,
  output logic             tick_o,
  output logic             clk_o,
  output logic             pend_o
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             clk_q, clk_d;
  // run_q is clear after reset and while halted; the first running edge
  // is treated as a period boundary so clk_o rises on that edge.
  logic             run_q, run_d;

  logic [DIV_W-1:0] hi;
  logic [DIV_W-1:0] cnt_inc;
  logic             wrap;
  ch_act_e          action;

  assign hi      = (act_q >> 1) + DIV_W'(act_q[0]);
  assign cnt_inc = count_q + DIV_W'(1);
  assign wrap    = (count_q == (act_q - DIV_W'(1)));

  always_comb begin
    if (!en_i || (act_q == '0)) begin
      action = ACT_HALT;
    end else if (sync_i || !run_q || wrap) begin
      action = ACT_BOUND;
    end else begin
      action = ACT_INC;
    end
  end

  always_comb begin
    count_d = count_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    run_d   = run_q;
    tick_d  = 1'b0;
    clk_d   = 1'b0;

    unique case (action)
      ACT_HALT: begin
        count_d = '0;
        run_d   = 1'b0;
        act_d   = shd_q;
        pend_d  = 1'b0;
      end
      ACT_BOUND: begin
        count_d = '0;
        run_d   = 1'b1;
        act_d   = shd_q;
        pend_d  = 1'b0;
        tick_d  = 1'b1;
        clk_d   = 1'b1;
      end
      default: begin
        count_d = cnt_inc;
        clk_d   = (cnt_inc < hi);
      end
    endcase

    // A write on an adoption edge lands after the old shadow was taken,
    // so it stays pending for the next boundary.
    if (wr_i) begin
      shd_d  = wr_val_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      act_q   <= DIV_W'(DEFAULT_DIV);
      shd_q   <= DIV_W'(DEFAULT_DIV);
      pend_q  <= 1'b0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
      clk_q   <= clk_d;
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = clk_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/clock_divider_multi.sv
// ---------------------------------------------------------------------------
// clock_divider_multi
//   Multi-channel run-time programmable clock divider / enable generator.
//   Decodes divisor writes to one channel and fans the global sync pulse
//   out to every channel. All outputs are registered inside the channels.
//
// Ports
//   clk50       in   1       system clock, posedge
//   rst_n       in   1       asynchronous active-low reset
//   ch_en       in   NUM_CH  per-channel run enable
//   sync_i      in   1       one-cycle pulse, restart all channel phases
//   div_wr_en   in   1       divisor write strobe
//   div_wr_ch   in   CH_W    channel index for the write
//   div_wr_val  in   DIV_W   new divisor
//   tick_o      out  NUM_CH  one-cycle strobe per period
//   clk_out     out  NUM_CH  divided square wave
//   pend_o      out  NUM_CH  shadow divisor pending adoption
// ---------------------------------------------------------------------------
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W       = idx_w(NUM_CH)
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_i,
  input  logic              div_wr_en,
  input  logic [CH_W-1:0]   div_wr_ch,
  input  logic [DIV_W-1:0]  div_wr_val,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr_hit;

    // Only indices 0..NUM_CH-1 can match, so an out-of-range write hits
    // no channel and is dropped.
    assign wr_hit = div_wr_en && (div_wr_ch == CH_W'(g));

    clk_div_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i    (clk50),
      .rst_ni   (rst_n),
      .en_i     (ch_en[g]),
      .sync_i   (sync_i),
      .wr_i     (wr_hit),
      .wr_val_i (div_wr_val),
      .tick_o   (tick_o[g]),
      .clk_o    (clk_out[g]),
      .pend_o   (pend_o[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
module tb_clock_divider_multi;

  logic       clk50 = 1'b0;
  logic       rst_n;
  logic [1:0] ch_en;
  logic       sync_i;
  logic       div_wr_en;
  logic [0:0] div_wr_ch;
  logic [7:0] div_wr_val;
  logic [1:0] tick_o;
  logic [1:0] clk_out;
  logic [1:0] pend_o;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [1:0] en;
    logic       sync;
    logic       wr;
    logic       ch;
    logic [7:0] val;
    logic [1:0] tick;
    logic [1:0] clk;
    logic [1:0] pend;
  } vec_t;

  vec_t tbl[$];

  clock_divider_multi #(
    .NUM_CH      (2),
    .DIV_W       (8),
    .DEFAULT_DIV (2)
  ) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .ch_en      (ch_en),
    .sync_i     (sync_i),
    .div_wr_en  (div_wr_en),
    .div_wr_ch  (div_wr_ch),
    .div_wr_val (div_wr_val),
    .tick_o     (tick_o),
    .clk_out    (clk_out),
    .pend_o     (pend_o)
  );

  always #5 clk50 = ~clk50;

  function automatic vec_t mk(input logic [1:0] en, input logic sync,
                              input logic wr, input logic ch, input logic [7:0] val,
                              input logic [1:0] tick, input logic [1:0] clk,
                              input logic [1:0] pend);
    vec_t v;
    v.en = en; v.sync = sync; v.wr = wr; v.ch = ch; v.val = val;
    v.tick = tick; v.clk = clk; v.pend = pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [1:0] et,
                       input logic [1:0] ec, input logic [1:0] ep);
    n_vec++;
    if (tick_o !== et || clk_out !== ec || pend_o !== ep) begin
      n_miss++;
      $display("FAIL %s: got tick=%b clk=%b pend=%b, expected tick=%b clk=%b pend=%b",
               name, tick_o, clk_out, pend_o, et, ec, ep);
    end
  endtask

  // Drive between edges, sample 1 time unit after the active edge.
  task automatic apply(input vec_t v, input string name);
    ch_en      = v.en;
    sync_i     = v.sync;
    div_wr_en  = v.wr;
    div_wr_ch  = v.ch;
    div_wr_val = v.val;
    @(posedge clk50);
    #1;
    check(name, v.tick, v.clk, v.pend);
  endtask

  initial begin
    // en, sync, wr, ch, val | tick, clk, pend
    // N=2 both channels, first edge after reset is a period start
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00)); // 1
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00)); // 5
    // ch1 <- 5 mid-period, pending until wrap, then 3 high / 2 low
    tbl.push_back(mk(2'b11, 0, 1, 1, 5, 2'b00, 2'b00, 2'b10));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00)); // 10
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00));
    // ch0: shadow 4 pending, then write 3 on the wrap edge
    tbl.push_back(mk(2'b11, 0, 1, 0, 4, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(2'b11, 0, 1, 0, 3, 2'b01, 2'b01, 2'b01)); // 15
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00));
    // ch0 <- 4, ch1 <- 6, adopted by sync; sync again mid-period
    tbl.push_back(mk(2'b11, 0, 1, 0, 4, 2'b00, 2'b01, 2'b01)); // 20
    tbl.push_back(mk(2'b11, 0, 1, 1, 6, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk(2'b11, 1, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(2'b11, 1, 0, 0, 0, 2'b11, 2'b11, 2'b00)); // 25
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00));
    // ch1 <- 0 halts after adoption; ch1 <- 1 adopted while halted
    tbl.push_back(mk(2'b11, 0, 1, 1, 0, 2'b00, 2'b01, 2'b10)); // 30
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00));
    tbl.push_back(mk(2'b11, 0, 1, 1, 1, 2'b00, 2'b01, 2'b10));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00)); // 35
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00));
    // ch1 disabled ignores sync; re-enable restarts the period
    tbl.push_back(mk(2'b01, 1, 0, 0, 0, 2'b01, 2'b01, 2'b00));
    tbl.push_back(mk(2'b11, 0, 0, 0, 0, 2'b10, 2'b11, 2'b00)); // 40
    // leave a write pending for the reset check
    tbl.push_back(mk(2'b11, 0, 1, 0, 7, 2'b10, 2'b10, 2'b01));

    rst_n      = 1'b0;
    ch_en      = 2'b11;
    sync_i     = 1'b0;
    div_wr_en  = 1'b0;
    div_wr_ch  = '0;
    div_wr_val = '0;
    #12;
    check("reset_state", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i + 1));

    // Asynchronous reset mid-period with ch0 write pending: no edge needed.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 2'b00, 2'b00, 2'b00);
    #3;
    rst_n = 1'b1;
    // Divisors back to 2 on both channels, pending write discarded.
    apply(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00), "post_reset_start");
    apply(mk(2'b11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00), "post_reset_low");
    apply(mk(2'b11, 0, 0, 0, 0, 2'b11, 2'b11, 2'b00), "post_reset_wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
